// File: rtl/clkrst_pkg.sv
// Shared types and constants for the clock/reset bring-up sequencer.
package clkrst_pkg;

  typedef enum logic [2:0] {
    StMmcmRst,
    StWaitLock,
    StIdlyRst,
    StWaitRdy,
    StSerdesRst,
    StRun,
    StFault
  } state_e;

  // Wide enough for the default lock timeout of 100000 cycles.
  localparam int unsigned CntWidth = 17;

  localparam int unsigned DefMmcmRstCycles   = 16;
  localparam int unsigned DefLockTimeout     = 100000;
  localparam int unsigned DefIdlyRstCycles   = 8;
  localparam int unsigned DefRdyTimeout      = 1000;
  localparam int unsigned DefSerdesRstCycles = 32;
  localparam int unsigned DefMaxRetry        = 15;

  typedef struct packed {
    logic mmcm_reset;
    logic idlyctrl_reset;
    logic serdes_reset;
    logic ready;
    logic fault;
  } outs_t;

  // Output levels that belong to a state; the top registers this for the next state.
  function automatic outs_t decode_outputs(state_e st);
    outs_t o;
    o.mmcm_reset     = (st == StMmcmRst) || (st == StFault);
    o.idlyctrl_reset = st inside {StMmcmRst, StWaitLock, StIdlyRst, StFault};
    o.serdes_reset   = (st != StRun);
    o.ready          = (st == StRun);
    o.fault          = (st == StFault);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the refclk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Only sync_q is safe to use; meta_q may be metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Clock/reset bring-up sequencer: MMCM reset, lock wait, IDELAYCTRL reset, RDY wait,
// SERDES reset hold, then RUN; bounded retries end in a terminal FAULT.
// Optional build macro CLKRST_LOCK_DEGLITCH_EN: lock/RDY loss acts only after four
// consecutive synchronized-low cycles instead of one.
module clock_reset_sequencer
  import clkrst_pkg::*;
#(
  parameter int unsigned MMCM_RST_CYCLES   = DefMmcmRstCycles,
  parameter int unsigned LOCK_TIMEOUT      = DefLockTimeout,
  parameter int unsigned IDLY_RST_CYCLES   = DefIdlyRstCycles,
  parameter int unsigned RDY_TIMEOUT       = DefRdyTimeout,
  parameter int unsigned SERDES_RST_CYCLES = DefSerdesRstCycles,
  parameter int unsigned MAX_RETRY         = DefMaxRetry
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       mmcm_locked,
  input  logic       idlyctrl_rdy,
  output logic       mmcm_reset,
  output logic       idlyctrl_reset,
  output logic       serdes_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  // Counter value on the last cycle of each state; the counter is 0 on the entry cycle.
  localparam logic [CntWidth-1:0] MmcmLast   = CntWidth'(MMCM_RST_CYCLES - 1);
  localparam logic [CntWidth-1:0] LockLast   = CntWidth'(LOCK_TIMEOUT - 1);
  localparam logic [CntWidth-1:0] IdlyLast   = CntWidth'(IDLY_RST_CYCLES - 1);
  localparam logic [CntWidth-1:0] RdyLast    = CntWidth'(RDY_TIMEOUT - 1);
  localparam logic [CntWidth-1:0] SerdesLast = CntWidth'(SERDES_RST_CYCLES - 1);
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);
  localparam logic [3:0]          RetryLimit = 4'(MAX_RETRY);

  logic lock_s;
  logic rdy_s;

  sync_2ff u_sync_lock (
    .clk (refclk),
    .rst (reset),
    .d   (mmcm_locked),
    .q   (lock_s)
  );

  sync_2ff u_sync_rdy (
    .clk (refclk),
    .rst (reset),
    .d   (idlyctrl_rdy),
    .q   (rdy_s)
  );

  logic lock_lost;
  logic rdy_lost;

`ifdef CLKRST_LOCK_DEGLITCH_EN
  logic [1:0] lock_low_q;
  logic [1:0] rdy_low_q;

  // Count preceding consecutive low cycles (saturating at 3); loss acts on the fourth.
  always_ff @(posedge refclk) begin
    if (reset) begin
      lock_low_q <= 2'd0;
      rdy_low_q  <= 2'd0;
    end else begin
      if (lock_s) begin
        lock_low_q <= 2'd0;
      end else if (lock_low_q != 2'd3) begin
        lock_low_q <= lock_low_q + 2'd1;
      end
      if (rdy_s) begin
        rdy_low_q <= 2'd0;
      end else if (rdy_low_q != 2'd3) begin
        rdy_low_q <= rdy_low_q + 2'd1;
      end
    end
  end

  assign lock_lost = !lock_s && (lock_low_q == 2'd3);
  assign rdy_lost  = !rdy_s && (rdy_low_q == 2'd3);
`else
  assign lock_lost = !lock_s;
  assign rdy_lost  = !rdy_s;
`endif

  state_e              state_q;
  state_e              state_d;
  logic [CntWidth-1:0] cnt_q;
  logic [3:0]          retry_q;
  logic [3:0]          retry_d;
  logic                timeout;
  outs_t               outs_q;

  // Next-state and retry bookkeeping; lock loss is checked before RDY loss so it wins.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timeout = 1'b0;
    unique case (state_q)
      StMmcmRst: begin
        if (cnt_q == MmcmLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s) state_d = StIdlyRst;
        else if (cnt_q == LockLast) timeout = 1'b1;
      end
      StIdlyRst: begin
        if (lock_lost) state_d = StMmcmRst;
        else if (cnt_q == IdlyLast) state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (lock_lost) state_d = StMmcmRst;
        else if (rdy_s) state_d = StSerdesRst;
        else if (cnt_q == RdyLast) timeout = 1'b1;
      end
      StSerdesRst: begin
        if (lock_lost) state_d = StMmcmRst;
        else if (rdy_lost) state_d = StIdlyRst;
        else if (cnt_q == SerdesLast) state_d = StRun;
      end
      StRun: begin
        if (lock_lost) state_d = StMmcmRst;
        else if (rdy_lost) state_d = StIdlyRst;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StMmcmRst;
      end
    endcase

    if (timeout) begin
      retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
      state_d = (retry_d == RetryLimit) ? StFault : StMmcmRst;
    end

    if ((state_d == StRun) && (state_q != StRun)) retry_d = 4'd0;
  end

  // State, shared counter and outputs decoded from the next state so they move together.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q <= StMmcmRst;
      cnt_q   <= '0;
      retry_q <= 4'd0;
      outs_q  <= decode_outputs(StMmcmRst);
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      outs_q  <= decode_outputs(state_d);
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q != StRun) && (state_q != StFault)) begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

  assign mmcm_reset     = outs_q.mmcm_reset;
  assign idlyctrl_reset = outs_q.idlyctrl_reset;
  assign serdes_reset   = outs_q.serdes_reset;
  assign ready          = outs_q.ready;
  assign fault          = outs_q.fault;
  assign retry_count    = retry_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Self-checking bench for clock_reset_sequencer: directed bring-up/fault scenarios plus
// random lock/RDY stimulus against a phase/elapsed-time reference model.
module tb_clock_reset_sequencer;

  localparam int MmcmLen   = 16;
  localparam int LockTo    = 200;
  localparam int IdlyLen   = 8;
  localparam int RdyTo     = 100;
  localparam int SerdesLen = 32;
  localparam int MaxRetry  = 15;

  logic       refclk = 1'b0;
  logic       reset;
  logic       mmcm_locked;
  logic       idlyctrl_rdy;
  logic       mmcm_reset;
  logic       idlyctrl_reset;
  logic       serdes_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;

  int errors = 0;
  int checks = 0;

  clock_reset_sequencer #(
    .MMCM_RST_CYCLES   (MmcmLen),
    .LOCK_TIMEOUT      (LockTo),
    .IDLY_RST_CYCLES   (IdlyLen),
    .RDY_TIMEOUT       (RdyTo),
    .SERDES_RST_CYCLES (SerdesLen),
    .MAX_RETRY         (MaxRetry)
  ) dut (
    .refclk         (refclk),
    .reset          (reset),
    .mmcm_locked    (mmcm_locked),
    .idlyctrl_rdy   (idlyctrl_rdy),
    .mmcm_reset     (mmcm_reset),
    .idlyctrl_reset (idlyctrl_reset),
    .serdes_reset   (serdes_reset),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count)
  );

  always #5 refclk = ~refclk;

  // ---------------- reference model: phase + time spent in phase ----------------
  localparam int PhMmcm = 0, PhLock = 1, PhIdly = 2, PhRdy = 3, PhSerdes = 4, PhRun = 5;
  localparam int PhFault = 6;

  int m_ph = PhMmcm;
  int m_age = 0;
  int m_retry = 0;
  int lk_low = 0;
  int rd_low = 0;
  bit lk_d1, lk_d2, rd_d1, rd_d2;

  task automatic model_edge(input logic rst, input logic lk, input logic rd);
    bit ls, rs, lost_l, lost_r, timed_out;
    int lasted, nxt;
    if (rst === 1'b1) begin
      m_ph = PhMmcm; m_age = 0; m_retry = 0; lk_low = 0; rd_low = 0;
      lk_d1 = 0; lk_d2 = 0; rd_d1 = 0; rd_d2 = 0;
    end else begin
      // decisions use the input level from two edges earlier
      ls = lk_d2; rs = rd_d2;
      lk_d2 = lk_d1; lk_d1 = (lk === 1'b1);
      rd_d2 = rd_d1; rd_d1 = (rd === 1'b1);
      lk_low = ls ? 0 : ((lk_low < 100) ? lk_low + 1 : lk_low);
      rd_low = rs ? 0 : ((rd_low < 100) ? rd_low + 1 : rd_low);
`ifdef CLKRST_LOCK_DEGLITCH_EN
      lost_l = (lk_low >= 4);
      lost_r = (rd_low >= 4);
`else
      lost_l = (lk_low >= 1);
      lost_r = (rd_low >= 1);
`endif
      lasted = m_age + 1;
      nxt = m_ph;
      timed_out = 0;
      case (m_ph)
        PhMmcm:   if (lasted == MmcmLen) nxt = PhLock;
        PhLock:   if (ls) nxt = PhIdly; else if (lasted == LockTo) timed_out = 1;
        PhIdly:   if (lost_l) nxt = PhMmcm; else if (lasted == IdlyLen) nxt = PhRdy;
        PhRdy:    if (lost_l) nxt = PhMmcm; else if (rs) nxt = PhSerdes;
                  else if (lasted == RdyTo) timed_out = 1;
        PhSerdes: if (lost_l) nxt = PhMmcm; else if (lost_r) nxt = PhIdly;
                  else if (lasted == SerdesLen) nxt = PhRun;
        PhRun:    if (lost_l) nxt = PhMmcm; else if (lost_r) nxt = PhIdly;
        default:  nxt = m_ph;
      endcase
      if (timed_out) begin
        if (m_retry < 15) m_retry = m_retry + 1;
        nxt = (m_retry == MaxRetry) ? PhFault : PhMmcm;
      end
      if (nxt == PhRun && m_ph != PhRun) m_retry = 0;
      m_age = (nxt == m_ph) ? lasted : 0;
      m_ph = nxt;
    end
  endtask

  function automatic logic [8:0] model_outs();
    logic hold_mmcm, hold_idly;
    hold_mmcm = (m_ph == PhMmcm) || (m_ph == PhFault);
    hold_idly = hold_mmcm || (m_ph == PhLock) || (m_ph == PhIdly);
    return {hold_mmcm, hold_idly, m_ph != PhRun, m_ph == PhRun, m_ph == PhFault, 4'(m_retry)};
  endfunction

  always @(posedge refclk) model_edge(reset, mmcm_locked, idlyctrl_rdy);

  // ---------------- stimulus helper ----------------
  task automatic bring_up(output bit ok);
    reset = 1'b1; mmcm_locked = 1'b1; idlyctrl_rdy = 1'b1;
    @(posedge refclk); #1;
    reset = 1'b0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge refclk); #1;
      if (ready === 1'b1) ok = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] got;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mmcm_locked = 1'($urandom_range(0, 1));
      idlyctrl_rdy = 1'($urandom_range(0, 1));
      @(posedge refclk); #1;
      got = {mmcm_reset, idlyctrl_reset, serdes_reset, ready, fault, retry_count};
      checks++;
      if (got !== 9'b111000000) begin
        errors++; $display("FAIL reset_state: got %b expected %b", got, 9'b111000000);
      end
    end
  endtask

  task automatic test_nominal();
    int fall_m = -1, fall_i = -1, rise_r = -1;
    reset = 1'b1; mmcm_locked = 1'b0; idlyctrl_rdy = 1'b0;
    @(posedge refclk); #1;  // cycle 0
    reset = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge refclk); #1;
      if (mmcm_reset === 1'b0 && fall_m < 0) fall_m = c;
      if (idlyctrl_reset === 1'b0 && fall_i < 0) fall_i = c;
      if (ready === 1'b1 && rise_r < 0) rise_r = c;
      if (c == 30) mmcm_locked = 1'b1;
      if (c == 60) idlyctrl_rdy = 1'b1;
    end
    checks++;
    if (fall_m != 16) begin errors++; $display("FAIL nominal_mmcm_fall: got %0d expected 16", fall_m); end
    checks++;
    if (fall_i != 41) begin errors++; $display("FAIL nominal_idly_fall: got %0d expected 41", fall_i); end
    checks++;
    if (rise_r - 60 != 35) begin
      errors++; $display("FAIL nominal_ready_delay: got %0d expected 35", rise_r - 60);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      errors++; $display("FAIL nominal_retry: got %0d expected 0", retry_count);
    end
    checks++;
    if ({ready, serdes_reset} !== 2'b10) begin
      errors++; $display("FAIL nominal_run_outputs: got %b expected 10", {ready, serdes_reset});
    end
  endtask

  task automatic test_no_lock();
    int run, pulses = 0, bad = 0;
    bit done = 0;
    reset = 1'b1; mmcm_locked = 1'b0; idlyctrl_rdy = 1'b0;
    @(posedge refclk); #1;
    reset = 1'b0;
    run = (mmcm_reset === 1'b1) ? 1 : 0;
    for (int c = 1; c < 4000 && !done; c++) begin
      @(posedge refclk); #1;
      if (fault === 1'b1) done = 1;
      else if (mmcm_reset === 1'b1) run++;
      else if (run > 0) begin
        pulses++;
        if (run != 16) bad++;
        run = 0;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL nolock_fault_reached: got 0 expected 1"); end
    checks++;
    if (pulses != 15) begin errors++; $display("FAIL nolock_pulses: got %0d expected 15", pulses); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL nolock_pulse_width: got %0d bad expected 0", bad); end
    checks++;
    if ({mmcm_reset, idlyctrl_reset, serdes_reset, ready} !== 4'b1110) begin
      errors++;
      $display("FAIL nolock_fault_outputs: got %b expected 1110",
               {mmcm_reset, idlyctrl_reset, serdes_reset, ready});
    end
    checks++;
    if (retry_count !== 4'd15) begin
      errors++; $display("FAIL nolock_retry: got %0d expected 15", retry_count);
    end
    mmcm_locked = 1'b1; idlyctrl_rdy = 1'b1;
    repeat (30) @(posedge refclk);
    #1;
    checks++;
    if ({fault, mmcm_reset, ready} !== 3'b110) begin
      errors++; $display("FAIL fault_terminal: got %b expected 110", {fault, mmcm_reset, ready});
    end
  endtask

  task automatic test_fault_reset();
    reset = 1'b1;
    @(posedge refclk); #1;
    reset = 1'b0;
    checks++;
    if ({fault, mmcm_reset} !== 2'b01) begin
      errors++; $display("FAIL fault_reset_outputs: got %b expected 01", {fault, mmcm_reset});
    end
    checks++;
    if (retry_count !== 4'd0) begin
      errors++; $display("FAIL fault_reset_retry: got %0d expected 0", retry_count);
    end
    @(posedge refclk); #1;
    checks++;
    if ({fault, mmcm_reset} !== 2'b01) begin
      errors++; $display("FAIL fault_restart: got %b expected 01", {fault, mmcm_reset});
    end
  endtask

  task automatic test_lock_glitch();
    bit ok, saw_drop = 0, saw_mmcm = 0, exp_change;
    bring_up(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL glitch_bringup: got 0 expected 1"); end
    repeat (3) @(posedge refclk);
    #1;
    mmcm_locked = 1'b0;
    @(posedge refclk); #1;
    mmcm_locked = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge refclk); #1;
      if (ready !== 1'b1) saw_drop = 1;
      if (mmcm_reset !== 1'b0) saw_mmcm = 1;
    end
`ifdef CLKRST_LOCK_DEGLITCH_EN
    exp_change = 0;
`else
    exp_change = 1;
`endif
    checks++;
    if (saw_drop != exp_change) begin
      errors++; $display("FAIL glitch_ready_drop: got %0d expected %0d", saw_drop, exp_change);
    end
    checks++;
    if (saw_mmcm != exp_change) begin
      errors++; $display("FAIL glitch_mmcm_pulse: got %0d expected %0d", saw_mmcm, exp_change);
    end
  endtask

  task automatic test_rdy_loss();
    bit ok, saw_mmcm = 0, saw_idly = 0, saw_drop = 0;
    int idly_fall = -1, ready_back = -1;
    bring_up(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rdyloss_bringup: got 0 expected 1"); end
    idlyctrl_rdy = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge refclk); #1;
      if (mmcm_reset !== 1'b0) saw_mmcm = 1;
      if (idlyctrl_reset === 1'b1) saw_idly = 1;
      if (saw_idly && idlyctrl_reset === 1'b0 && idly_fall < 0) idly_fall = i;
      if (ready === 1'b0) saw_drop = 1;
      if (saw_drop && ready === 1'b1 && ready_back < 0) ready_back = i;
      if (i == 5) idlyctrl_rdy = 1'b1;
    end
    checks++;
    if (saw_mmcm) begin errors++; $display("FAIL rdyloss_mmcm_quiet: got 1 expected 0"); end
    checks++;
    if (!saw_idly) begin errors++; $display("FAIL rdyloss_idly_reentry: got 0 expected 1"); end
    // one WAIT_RDY cycle (RDY already back) followed by the 32-cycle SERDES reset hold
    checks++;
    if (idly_fall < 0 || ready_back - idly_fall != 33) begin
      errors++;
      $display("FAIL rdyloss_serdes_hold: got %0d expected 33", ready_back - idly_fall);
    end
  endtask

  task automatic test_both_drop();
    bit ok, seen = 0;
    logic mmcm_at_fall = 1'b0;
    bring_up(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL both_bringup: got 0 expected 1"); end
    mmcm_locked = 1'b0; idlyctrl_rdy = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge refclk); #1;
      if (!seen && ready === 1'b0) begin seen = 1; mmcm_at_fall = mmcm_reset; end
      if (i == 5) begin mmcm_locked = 1'b1; idlyctrl_rdy = 1'b1; end
    end
    checks++;
    if (!seen || mmcm_at_fall !== 1'b1) begin
      errors++; $display("FAIL both_lock_wins: got %b expected 1", mmcm_at_fall);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      errors++; $display("FAIL both_retry: got %0d expected 0", retry_count);
    end
  endtask

  task automatic test_run_reset();
    bit ok;
    int fall_m = -1;
    bring_up(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL runrst_bringup: got 0 expected 1"); end
    reset = 1'b1;
    @(posedge refclk); #1;  // cycle 0
    reset = 1'b0;
    checks++;
    if ({ready, mmcm_reset} !== 2'b01) begin
      errors++; $display("FAIL runrst_outputs: got %b expected 01", {ready, mmcm_reset});
    end
    for (int c = 1; c <= 30; c++) begin
      @(posedge refclk); #1;
      if (mmcm_reset === 1'b0 && fall_m < 0) fall_m = c;
    end
    checks++;
    if (fall_m != 16) begin errors++; $display("FAIL runrst_mmcm_fall: got %0d expected 16", fall_m); end
  endtask

  task automatic test_random();
    int lk_off = 0, rd_off = 0, r;
    logic [8:0] got, exp;
    reset = 1'b1; mmcm_locked = 1'b0; idlyctrl_rdy = 1'b0;
    @(posedge refclk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (lk_off == 0) begin
        r = $urandom_range(0, 999);
        if (r < 2) lk_off = $urandom_range(250, 450);
        else if (r < 12) lk_off = $urandom_range(1, 6);
      end
      if (rd_off == 0) begin
        r = $urandom_range(0, 999);
        if (r < 3) rd_off = $urandom_range(120, 200);
        else if (r < 15) rd_off = $urandom_range(1, 6);
      end
      mmcm_locked = (lk_off == 0);
      idlyctrl_rdy = (rd_off == 0);
      if (lk_off > 0) lk_off--;
      if (rd_off > 0) rd_off--;
      reset = ($urandom_range(0, 1999) == 0);
      @(posedge refclk); #1;
      got = {mmcm_reset, idlyctrl_reset, serdes_reset, ready, fault, retry_count};
      exp = model_outs();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle_%0d: got %b expected %b", i, got, exp);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mmcm_locked = 1'b0; idlyctrl_rdy = 1'b0;
    test_reset();
    test_nominal();
    test_no_lock();
    test_fault_reset();
    test_lock_glitch();
    test_rdy_loss();
    test_both_drop();
    test_run_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clock_reset_sequencer.md
CLOCK_RESET_SEQUENCER -- requirements
Module: clock_reset_sequencer

Interface
REQ-001 SHALL have parameter MMCM_RST_CYCLES, default 16: mmcm_reset pulse width in refclk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 100000: maximum cycles to wait for lock.
REQ-003 SHALL have parameter IDLY_RST_CYCLES, default 8: idlyctrl_reset pulse width.
REQ-004 SHALL have parameter RDY_TIMEOUT, default 1000: maximum cycles to wait for IDELAYCTRL ready.
REQ-005 SHALL have parameter SERDES_RST_CYCLES, default 32: serdes_reset hold after ready.
REQ-006 SHALL have parameter MAX_RETRY, default 15: number of timeouts before fault; range 1..15.
REQ-007 SHALL have port refclk, input, 1: single free-running clock, 100 MHz.
REQ-008 SHALL have port reset, input, 1: reset, synchronous to refclk, active-high.
REQ-009 SHALL have port mmcm_locked, input, 1: MMCM lock, asynchronous.
REQ-010 SHALL have port idlyctrl_rdy, input, 1: IDELAYCTRL RDY, asynchronous.
REQ-011 SHALL have port mmcm_reset, output, 1: drives the MMCM RST input.
REQ-012 SHALL have port idlyctrl_reset, output, 1: IDELAYCTRL reset.
REQ-013 SHALL have port serdes_reset, output, 1: ISERDES/OSERDES reset, which downstream resynchronizes.
REQ-014 SHALL have port ready, output, 1: clocking is up and SERDES is out of reset.
REQ-015 SHALL have port fault, output, 1: retries are exhausted.
REQ-016 SHALL have port retry_count, output, 4: count of timeouts since the last RUN.

Function
REQ-017 SHALL pass mmcm_locked and idlyctrl_rdy through 2-flop synchronizers (2-cycle latency); all decisions SHALL use the synchronized values.
REQ-018 SHALL implement the FSM states MMCM_RST, WAIT_LOCK, IDLY_RST, WAIT_RDY, SERDES_RST, RUN and FAULT, with one shared cycle counter that is cleared on every state entry.
REQ-019 MMCM_RST SHALL move to WAIT_LOCK after exactly MMCM_RST_CYCLES cycles.
REQ-020 WAIT_LOCK SHALL move to IDLY_RST on a synchronized lock; when the counter reaches LOCK_TIMEOUT it SHALL take a timeout.
REQ-021 IDLY_RST SHALL move to WAIT_RDY after IDLY_RST_CYCLES cycles.
REQ-022 WAIT_RDY SHALL move to SERDES_RST on a synchronized RDY; when the counter reaches RDY_TIMEOUT it SHALL take a timeout.
REQ-023 SERDES_RST SHALL move to RUN after SERDES_RST_CYCLES cycles.
REQ-024 On a timeout, the FSM SHALL increment retry_count; if the new value equals MAX_RETRY it SHALL go to FAULT, otherwise to MMCM_RST.
REQ-025 Loss of lock in IDLY_RST, WAIT_RDY, SERDES_RST or RUN SHALL go to MMCM_RST without incrementing retry_count.
REQ-026 Loss of RDY in SERDES_RST or RUN SHALL go to IDLY_RST.
REQ-027 When lock loss and RDY loss occur in the same cycle, lock loss SHALL win.
REQ-028 Entry to RUN SHALL clear retry_count; retry_count SHALL saturate and never wrap.
REQ-029 FAULT SHALL be terminal until reset, with mmcm_reset, idlyctrl_reset and serdes_reset all asserted.
REQ-030 All outputs SHALL be registered and decoded from the next state, so each output changes in the same cycle as the state change.
REQ-031 mmcm_reset SHALL be asserted only in MMCM_RST and FAULT.
REQ-032 idlyctrl_reset SHALL be asserted in MMCM_RST, WAIT_LOCK, IDLY_RST and FAULT.
REQ-033 serdes_reset SHALL be asserted in every state except RUN.
REQ-034 ready SHALL be asserted only in RUN.

Reset
REQ-035 While reset is high, the block SHALL set state=MMCM_RST, counter=0, synchronizers=0, mmcm_reset=1, idlyctrl_reset=1, serdes_reset=1, ready=0, fault=0, retry_count=0.
REQ-036 Reset asserted mid-sequence, including in FAULT or RUN, SHALL restart from MMCM_RST on the next cycle with no residual count.

Configuration
REQ-037 SHALL support the macro CLKRST_LOCK_DEGLITCH_EN: when defined, loss of lock or RDY SHALL act only after 4 consecutive synchronized-low cycles; when undefined, a single synchronized-low cycle SHALL act.

Structure
REQ-038 Package clkrst_pkg SHALL hold the state enumeration, the counter width constant (17 bits, sized for LOCK_TIMEOUT) and the default parameter values.
REQ-039 A sub-module sync_2ff SHALL implement the synchronizer and be instantiated twice.

Verification
REQ-040 Nominal bring-up: release reset at cycle 0, mmcm_locked=1 from cycle 30, idlyctrl_rdy=1 from cycle 60 -> mmcm_reset falls at cycle 16, ready rises 35 cycles after RDY rises, retry_count=0.
REQ-041 Lock never asserted -> 15 MMCM_RST pulses of 16 cycles each, then fault=1 with all resets high, retry_count=15.
REQ-042 In RUN, mmcm_locked low for 1 cycle -> with CLKRST_LOCK_DEGLITCH_EN undefined, ready=0 and a mmcm_reset pulse follows; with it defined, there is no change.
REQ-043 In RUN, idlyctrl_rdy low -> the FSM re-enters IDLY_RST, mmcm_reset stays 0, then a 32-cycle serdes_reset follows before ready returns.
REQ-044 Lock and RDY dropped in the same cycle -> the FSM enters MMCM_RST, not IDLY_RST.
REQ-045 Reset pulsed for 1 cycle while in FAULT -> fault=0 and the sequence restarts with mmcm_reset=1.
